abacus_event_counter_bank: RTL and testbench

Parametrised successor to the fixed instruction/cache counter bank. Provides NUM_CHANNELS generic event counters of COUNTER_WIDTH bits behind one Wishbone slave window. Adds per-channel enable, wrap or saturate mode, sticky overflow flags, and coherent snapshot readout. Adds a hardware measurement window that stops counting after a programmed number of cycles. Sits beside the core and takes single-cycle event strobes from any profiling source.

---
 rtl/abacus_event_counter_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_abacus_event_counter_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/abacus_event_counter_bank.sv
// rtl/abacus_event_counter_bank.sv - parametrised event counter bank with Wishbone window, measurement window and snapshots.
// Optional overflow/window interrupt logic is built when ABACUS_COUNTER_IRQ_EN is defined.
module abacus_event_counter_bank #(
    parameter logic [31:0] BASE_ADDR     = 32'hf0030000,
    parameter int          NUM_CHANNELS  = 8,
    parameter int          COUNTER_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] events,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [31:0]             wb_adr,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack,
    output logic                    irq
);

    localparam int N  = NUM_CHANNELS;
    localparam int CW = COUNTER_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          enable_q, enable_d;
    logic          sat_q, sat_d;
    logic          wmode_q, wmode_d;
    logic [N-1:0]  chan_en_q, chan_en_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [31:0]   win_len_q, win_len_d;
    logic [31:0]   remain_q, remain_d;
    logic [1:0]    state_q, state_d;
    logic          wdone_q, wdone_d;
    logic [31:0]   irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [CW-1:0] snap_q [N];
    logic [CW-1:0] snap_d [N];

    logic        req, in_win, wr;
    logic [11:0] off;
    logic        wr_ctrl, wr_chan, wr_ovf, wr_wlen, wr_status, wr_irqen;
    logic        clear, snap_take, wdone_set, count_ok;
    logic [N-1:0] ovf_set;
    logic [31:0] rdata;
    logic [63:0] snap_ext;

    assign req       = wb_cyc & wb_stb & ~ack_q;
    assign in_win    = (wb_adr[31:12] == BASE_ADDR[31:12]);
    assign off       = wb_adr[11:0];
    assign wr        = req & wb_we & in_win;
    assign wr_ctrl   = wr && (off == 12'h000);
    assign wr_chan   = wr && (off == 12'h004);
    assign wr_ovf    = wr && (off == 12'h008);
    assign wr_wlen   = wr && (off == 12'h00C);
    assign wr_status = wr && (off == 12'h014);
    assign wr_irqen  = wr && (off == 12'h018);
    assign clear     = wr_ctrl & wb_dat_i[2];

    always_comb begin
        enable_d  = enable_q;
        sat_d     = sat_q;
        wmode_d   = wmode_q;
        chan_en_d = chan_en_q;
        win_len_d = win_len_q;
        remain_d  = remain_q;
        state_d   = state_q;
        wdone_d   = wdone_q;
        ovf_set   = '0;
        wdone_set = 1'b0;
        snap_take = wr_ctrl & wb_dat_i[3];

        if (wr_ctrl) begin
            enable_d = wb_dat_i[0];
            sat_d    = wb_dat_i[1];
            wmode_d  = wb_dat_i[4];
        end
        if (wr_chan) chan_en_d = wb_dat_i[N-1:0];
        if (wr_wlen) win_len_d = wb_dat_i;

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && wb_dat_i[0] && wb_dat_i[4]) begin
                    remain_d = win_len_q;
                    if (win_len_q == 32'd0) begin
                        state_d   = ST_DONE;
                        enable_d  = 1'b0;
                        snap_take = 1'b1;
                        wdone_set = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // The DONE transition happens one cycle after REMAIN hits 0 so the
                // automatic snapshot includes the event counted on the last window cycle.
                if (remain_q != 32'd0) begin
                    remain_d = remain_q - 32'd1;
                end else begin
                    state_d   = ST_DONE;
                    enable_d  = 1'b0;
                    snap_take = 1'b1;
                    wdone_set = 1'b1;
                end
            end
            ST_DONE: begin
                if (wr_ctrl && (!wb_dat_i[0] || wb_dat_i[2])) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        count_ok = enable_q && (state_q != ST_DONE) &&
                   !((state_q == ST_RUN) && (remain_q == 32'd0));

        for (int i = 0; i < N; i++) begin
            cnt_d[i]  = cnt_q[i];
            snap_d[i] = snap_take ? cnt_q[i] : snap_q[i];
            if (count_ok && chan_en_q[i] && events[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                    if (!sat_q) cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
            if (clear) cnt_d[i] = '0;
        end

        // A fresh overflow beats a simultaneous write-1-to-clear.
        ovf_d = (ovf_q & ~(wr_ovf ? wb_dat_i[N-1:0] : {N{1'b0}})) | ovf_set;
        if (clear) ovf_d = '0;

        if (wr_status && wb_dat_i[2]) wdone_d = 1'b0;
        if (wdone_set) wdone_d = 1'b1;
        if (clear) wdone_d = 1'b0;

`ifdef ABACUS_COUNTER_IRQ_EN
        irq_en_d = wr_irqen ? wb_dat_i : irq_en_q;
        irq_d    = (|(ovf_q & irq_en_q[N-1:0])) | (wdone_q & irq_en_q[31]);
`else
        irq_en_d = {31'd0, wr_irqen & 1'b0};
        irq_d    = 1'b0;
`endif
    end

    always_comb begin
        rdata    = '0;
        snap_ext = '0;
        if (in_win) begin
            case (off)
                12'h000: rdata = {27'd0, wmode_q, 2'b00, sat_q, enable_q};
                12'h004: rdata = 32'(chan_en_q);
                12'h008: rdata = 32'(ovf_q);
                12'h00C: rdata = win_len_q;
                12'h010: rdata = remain_q;
                12'h014: rdata = {29'd0, wdone_q, state_q};
                12'h018: rdata = irq_en_q;
                default: rdata = '0;
            endcase
            for (int i = 0; i < N; i++) begin
                if (off[11:8] == 4'h1 && off[7:3] == 5'(i) && off[1:0] == 2'b00) begin
                    snap_ext = 64'(snap_q[i]);
                    rdata    = off[2] ? snap_ext[63:32] : snap_ext[31:0];
                end
            end
        end
        ack_d = req;
        dat_d = (req && !wb_we) ? rdata : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            enable_q  <= 1'b0;
            sat_q     <= 1'b0;
            wmode_q   <= 1'b0;
            chan_en_q <= '0;
            ovf_q     <= '0;
            win_len_q <= '0;
            remain_q  <= '0;
            state_q   <= ST_IDLE;
            wdone_q   <= 1'b0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            enable_q  <= enable_d;
            sat_q     <= sat_d;
            wmode_q   <= wmode_d;
            chan_en_q <= chan_en_d;
            ovf_q     <= ovf_d;
            win_len_q <= win_len_d;
            remain_q  <= remain_d;
            state_q   <= state_d;
            wdone_q   <= wdone_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_abacus_event_counter_bank.sv
// tb/tb_abacus_event_counter_bank.sv - directed self-checking bench for abacus_event_counter_bank.
module tb_abacus_event_counter_bank;

    localparam logic [31:0] BASE = 32'hf0030000;
`ifdef ABACUS_COUNTER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  events = '0;
    logic [7:0]  ev_hold = '0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, irq;
    logic [31:0] rd;

    int n_tests = 0;
    int n_fail  = 0;

    abacus_event_counter_bank #(
        .BASE_ADDR(BASE), .NUM_CHANNELS(8), .COUNTER_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .events(events),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [11:0] off, input logic [31:0] data, input logic [7:0] ev);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = BASE + 32'(off); wb_dat_i = data;
        events = ev_hold | ev;
        @(posedge clk); #1;
        check("wr_ack", {31'd0, wb_ack}, 32'd1);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        events = ev_hold;
    endtask

    task automatic wb_read(input logic [11:0] off, output logic [31:0] data);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = BASE + 32'(off);
        @(posedge clk); #1;
        check("rd_ack", {31'd0, wb_ack}, 32'd1);
        data = wb_dat_o;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [11:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(off, d);
        check(tag, d, exp);
    endtask

    task automatic events_for(input logic [7:0] mask, input int n);
        @(negedge clk);
        events = ev_hold | mask;
        repeat (n) @(negedge clk);
        events = ev_hold;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        for (int a = 0; a <= 12'h018; a += 4) check_rd("rst_reg", 12'(a), 32'd0);
        for (int a = 12'h100; a < 12'h140; a += 4) check_rd("rst_snap", 12'(a), 32'd0);

        // basic counting
        wb_write(12'h004, 32'h3, 8'h0);
        wb_write(12'h000, 32'h1, 8'h0);
        events_for(8'h03, 3);
        events_for(8'h01, 2);
        wb_write(12'h000, 32'h9, 8'h0);
        check_rd("snap0", 12'h100, 32'd5);
        check_rd("snap1", 12'h108, 32'd3);
        check_rd("snap0_hi", 12'h104, 32'd0);
        check_rd("chan_en", 12'h004, 32'h3);
        check_rd("ctrl_pulses_read0", 12'h000, 32'h1);
        check_rd("unmapped", 12'h140, 32'd0);

        // wrap
        wb_write(12'h000, 32'h5, 8'h0);
        wb_write(12'h004, 32'h4, 8'h0);
        events_for(8'h04, 16);
        wb_write(12'h000, 32'h9, 8'h0);
        check_rd("wrap_snap2", 12'h110, 32'd0);
        check_rd("wrap_ovf", 12'h008, 32'h4);
        wb_write(12'h008, 32'h4, 8'h0);
        check_rd("ovf_w1c", 12'h008, 32'h0);

        // saturate
        wb_write(12'h000, 32'h7, 8'h0);
        events_for(8'h04, 20);
        wb_write(12'h000, 32'hB, 8'h0);
        check_rd("sat_snap2", 12'h110, 32'hF);
        check_rd("sat_ovf", 12'h008, 32'h4);
        wb_write(12'h008, 32'h4, 8'h04);
        check_rd("ovf_set_beats_w1c", 12'h008, 32'h4);

        // measurement window of 10 with events[0] held high
        wb_write(12'h000, 32'h4, 8'h0);
        wb_write(12'h004, 32'h1, 8'h0);
        wb_write(12'h00C, 32'd10, 8'h0);
        check_rd("win_len", 12'h00C, 32'd10);
        @(negedge clk);
        ev_hold = 8'h01; events = 8'h01;
        wb_write(12'h000, 32'h11, 8'h0);
        check_rd("remain_run", 12'h010, 32'd9);
        check_rd("status_run", 12'h014, 32'h1);
        repeat (12) @(negedge clk);
        check_rd("win_snap0", 12'h100, 32'd10);
        check_rd("win_status", 12'h014, 32'h6);
        check_rd("win_ctrl", 12'h000, 32'h10);
        check_rd("win_remain", 12'h010, 32'd0);

        // zero-length window
        wb_write(12'h000, 32'h4, 8'h0);
        check_rd("status_idle", 12'h014, 32'h0);
        wb_write(12'h00C, 32'd0, 8'h0);
        wb_write(12'h000, 32'h11, 8'h0);
        repeat (3) @(negedge clk);
        check_rd("win0_snap0", 12'h100, 32'd0);
        check_rd("win0_status", 12'h014, 32'h6);
        ev_hold = 8'h0; events = 8'h0;

        // clear/snapshot collisions with an event at the same edge
        wb_write(12'h000, 32'h4, 8'h0);
        wb_write(12'h000, 32'h1, 8'h0);
        events_for(8'h01, 3);
        wb_write(12'h000, 32'h5, 8'h01);
        wb_write(12'h000, 32'h9, 8'h0);
        check_rd("clear_beats_event", 12'h100, 32'd0);
        events_for(8'h01, 3);
        wb_write(12'h000, 32'h9, 8'h01);
        check_rd("snap_old_value", 12'h100, 32'd3);
        wb_write(12'h000, 32'h9, 8'h0);
        check_rd("snap_after_event", 12'h100, 32'd4);

        // window-done interrupt
        wb_write(12'h000, 32'h4, 8'h0);
        wb_write(12'h018, 32'h8000_0000, 8'h0);
        check_rd("irq_en", 12'h018, IRQ_ON ? 32'h8000_0000 : 32'h0);
        wb_write(12'h00C, 32'd4, 8'h0);
        wb_write(12'h000, 32'h11, 8'h0);
        repeat (5) @(negedge clk);
        check("irq_before", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
        wb_write(12'h014, 32'h4, 8'h0);
        check("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        check_rd("status_wd_cleared", 12'h014, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
